// File: rtl/mem_cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache placed
// between the MEM stage and the SRAM controller. Read hits complete in the
// request cycle; misses and all writes are forwarded to the SRAM controller
// and hold `ready` low until its one-cycle completion pulse.
module mem_cache_controller #(
    parameter int SETS    = 64,
    parameter int INDEX_W = 6,
    parameter int TAG_W   = 11
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] wdata,
    input  logic        MEM_R_EN,
    input  logic        MEM_W_EN,
    output logic [31:0] rdata,
    output logic        ready,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    output logic        sram_w_en,
    output logic        sram_r_en,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MISS_READ  = 2'd1,
        WRITE_THRU = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Control state: cleared by reset.
    logic [SETS-1:0] valid0_q, valid0_d;
    logic [SETS-1:0] valid1_q, valid1_d;
    logic [SETS-1:0] lru_q, lru_d;

    // Tag/data arrays: contents only matter where the matching valid bit is set.
    logic [TAG_W-1:0] tag0_q  [SETS];
    logic [TAG_W-1:0] tag1_q  [SETS];
    logic [31:0]      data0_q [SETS];
    logic [31:0]      data1_q [SETS];

    // Array write strobes and write data, produced by the FSM.
    logic        tag_wr0, tag_wr1;
    logic        data_wr0, data_wr1;
    logic [31:0] data_wval;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit0, hit1, hit;
    logic               fill_way1;
    logic               unused_addr;

    assign idx = address[INDEX_W+1:2];
    assign tag = address[TAG_W+INDEX_W+1:INDEX_W+2];

    // Byte offset and bits above the tag do not take part in the lookup.
    assign unused_addr = ^{address[31:TAG_W+INDEX_W+2], address[1:0]};

    assign hit0 = valid0_q[idx] && (tag0_q[idx] == tag);
    assign hit1 = valid1_q[idx] && (tag1_q[idx] == tag);
    assign hit  = hit0 || hit1;

    // Prefer an empty way; only evict the LRU victim when both ways are valid.
    assign fill_way1 = valid0_q[idx] && (!valid1_q[idx] || lru_q[idx]);

    assign sram_address = address;
    assign sram_wdata   = wdata;

    // Control registers: state, valid and LRU bits, synchronously cleared on rst low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            valid0_q <= '0;
            valid1_q <= '0;
            lru_q    <= '0;
        end else begin
            state_q  <= state_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            lru_q    <= lru_d;
        end
    end

    // Tag/data array writes; suppressed during reset so an abandoned miss never fills.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (tag_wr0)  tag0_q[idx]  <= tag;
            if (tag_wr1)  tag1_q[idx]  <= tag;
            if (data_wr0) data0_q[idx] <= data_wval;
            if (data_wr1) data1_q[idx] <= data_wval;
        end
    end

    // Next-state, array update and output decode.
    always_comb begin
        state_d   = state_q;
        valid0_d  = valid0_q;
        valid1_d  = valid1_q;
        lru_d     = lru_q;
        tag_wr0   = 1'b0;
        tag_wr1   = 1'b0;
        data_wr0  = 1'b0;
        data_wr1  = 1'b0;
        data_wval = wdata;
        ready     = 1'b1;
        rdata     = '0;
        sram_r_en = 1'b0;
        sram_w_en = 1'b0;

        case (state_q)
            IDLE: begin
                if (MEM_W_EN) begin
                    ready   = 1'b0;
                    state_d = WRITE_THRU;
                end else if (MEM_R_EN) begin
                    if (hit) begin
                        rdata      = hit0 ? data0_q[idx] : data1_q[idx];
                        lru_d[idx] = hit0;
                    end else begin
                        ready   = 1'b0;
                        state_d = MISS_READ;
                    end
                end
            end

            MISS_READ: begin
                sram_r_en = 1'b1;
                ready     = 1'b0;
                if (sram_ready) begin
                    ready     = 1'b1;
                    rdata     = sram_rdata;
                    data_wval = sram_rdata;
                    if (fill_way1) begin
                        tag_wr1       = 1'b1;
                        data_wr1      = 1'b1;
                        valid1_d[idx] = 1'b1;
                        lru_d[idx]    = 1'b0;
                    end else begin
                        tag_wr0       = 1'b1;
                        data_wr0      = 1'b1;
                        valid0_d[idx] = 1'b1;
                        lru_d[idx]    = 1'b1;
                    end
                    state_d = IDLE;
                end
            end

            WRITE_THRU: begin
                sram_w_en = 1'b1;
                ready     = 1'b0;
                if (sram_ready) begin
                    ready = 1'b1;
                    if (hit0) begin
                        data_wr0   = 1'b1;
                        lru_d[idx] = 1'b1;
                    end else if (hit1) begin
                        data_wr1   = 1'b1;
                        lru_d[idx] = 1'b0;
                    end
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_cache_controller.sv
// Self-checking bench for mem_cache_controller: directed scenarios plus a
// randomized run, all checked against an array-based cache/SRAM model.
module tb_mem_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] address, wdata, rdata, sram_address, sram_wdata, sram_rdata;
    logic        MEM_R_EN, MEM_W_EN, ready, sram_w_en, sram_r_en, sram_ready;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per-set two-way cache state and a word-addressed backing store.
    bit          mv0 [64];
    bit          mv1 [64];
    bit          mlru[64];
    logic [10:0] mt0 [64];
    logic [10:0] mt1 [64];
    logic [31:0] md0 [64];
    logic [31:0] md1 [64];
    logic [31:0] mem [bit [29:0]];

    // Observations from the most recent access.
    int          low, rcyc, wcyc;
    bit          both, en_after, pass_ok, tmo, sop;
    logic [31:0] rd, erd;

    mem_cache_controller #(.SETS(64), .INDEX_W(6), .TAG_W(11)) dut (
        .clk(clk), .rst(rst), .address(address), .wdata(wdata),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .rdata(rdata), .ready(ready),
        .sram_address(sram_address), .sram_wdata(sram_wdata),
        .sram_w_en(sram_w_en), .sram_r_en(sram_r_en),
        .sram_rdata(sram_rdata), .sram_ready(sram_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            mv0[i] = 0; mv1[i] = 0; mlru[i] = 0;
        end
    endtask

    // Predicts whether the access goes to SRAM and the load data it returns, then updates the model.
    task automatic model_step(input logic re, input logic we, input logic [31:0] a, input logic [31:0] wd);
        int i;
        logic [10:0] t;
        bit h0, h1, way1;
        i  = int'(a[7:2]);
        t  = a[18:8];
        h0 = mv0[i] && (mt0[i] == t);
        h1 = mv1[i] && (mt1[i] == t);
        sop = 0;
        erd = 32'h0;
        if (we) begin
            sop = 1;
            if (h0) begin md0[i] = wd; mlru[i] = 1; end
            else if (h1) begin md1[i] = wd; mlru[i] = 0; end
            mem[a[31:2]] = wd;
        end else if (re) begin
            if (h0) begin erd = md0[i]; mlru[i] = 1; end
            else if (h1) begin erd = md1[i]; mlru[i] = 0; end
            else begin
                sop  = 1;
                erd  = mem_rd(a);
                way1 = !mv0[i] ? 1'b0 : (!mv1[i] ? 1'b1 : mlru[i]);
                if (way1) begin mv1[i] = 1; mt1[i] = t; md1[i] = erd; mlru[i] = 0; end
                else begin mv0[i] = 1; mt0[i] = t; md0[i] = erd; mlru[i] = 1; end
            end
        end
    endtask

    // Drives one MEM request and plays the SRAM controller with `lat` wait cycles before its pulse.
    task automatic access(input logic re, input logic we, input logic [31:0] a, input logic [31:0] wd, input int lat);
        int  en_cnt;
        bit  done;
        low = 0; rcyc = 0; wcyc = 0; both = 0; rd = '0;
        en_after = 0; pass_ok = 1; tmo = 0; en_cnt = 0; done = 0;
        @(negedge clk);
        MEM_R_EN = re; MEM_W_EN = we; address = a; wdata = wd; sram_ready = 0;
        for (int c = 0; c < 200 && !done; c++) begin
            if (c != 0) @(negedge clk);
            #1;
            sram_ready = (sram_r_en || sram_w_en) && (en_cnt == lat);
            sram_rdata = sram_r_en ? mem_rd(a) : 32'h0BAD_0BAD;
            #1;
            if (sram_r_en) rcyc++;
            if (sram_w_en) wcyc++;
            if (sram_r_en && sram_w_en) both = 1;
            if (sram_address !== a || sram_wdata !== wd) pass_ok = 0;
            if (sram_r_en || sram_w_en) en_cnt++;
            if (ready === 1'b1) begin rd = rdata; done = 1; end
            else low++;
        end
        if (!done) tmo = 1;
        @(negedge clk);
        MEM_R_EN = 0; MEM_W_EN = 0; sram_ready = 0;
        #1;
        en_after = sram_r_en || sram_w_en;
    endtask

    task automatic test_reset();
        rst = 0; MEM_R_EN = 0; MEM_W_EN = 0; address = 0; wdata = 0;
        sram_ready = 0; sram_rdata = 0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (ready !== 1'b1 || sram_r_en !== 1'b0 || sram_w_en !== 1'b0 || rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: ready=%b r_en=%b w_en=%b rdata=%h, want 1 0 0 0", ready, sram_r_en, sram_w_en, rdata);
        end
        rst = 1;
        model_reset();
    endtask

    task automatic test_cold_read();
        mem[30'h101] = 32'hDEAD_BEEF;
        model_step(1, 0, 32'h0000_0404, 0);
        access(1, 0, 32'h0000_0404, 0, 5);
        n_tests++;
        if (low !== 6) begin n_fail++; $display("FAIL cold_ready_low: got %0d cycles want 6", low); end
        n_tests++;
        if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL cold_rdata: got %h want deadbeef", rd); end
        n_tests++;
        if (rcyc !== 6 || wcyc !== 0 || en_after !== 0) begin
            n_fail++; $display("FAIL cold_enables: r=%0d w=%0d after=%0d want 6 0 0", rcyc, wcyc, en_after);
        end
        model_step(1, 0, 32'h0000_0404, 0);
        access(1, 0, 32'h0000_0404, 0, 5);
        n_tests++;
        if (low !== 0 || rcyc !== 0 || rd !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL cold_rehit: low=%0d r=%0d rdata=%h want 0 0 deadbeef", low, rcyc, rd);
        end
    endtask

    task automatic test_write_hit();
        model_step(0, 1, 32'h0000_0404, 32'h1234_5678);
        access(0, 1, 32'h0000_0404, 32'h1234_5678, 3);
        n_tests++;
        if (wcyc !== 4 || rcyc !== 0 || low !== 4 || en_after !== 0) begin
            n_fail++; $display("FAIL whit_enables: w=%0d r=%0d low=%0d after=%0d want 4 0 4 0", wcyc, rcyc, low, en_after);
        end
        model_step(1, 0, 32'h0000_0404, 0);
        access(1, 0, 32'h0000_0404, 0, 3);
        n_tests++;
        if (low !== 0 || rd !== 32'h1234_5678) begin
            n_fail++; $display("FAIL whit_readback: low=%0d rdata=%h want 0 12345678", low, rd);
        end
    endtask

    task automatic test_write_miss();
        model_step(0, 1, 32'h0000_0808, 32'hCAFE_F00D);
        access(0, 1, 32'h0000_0808, 32'hCAFE_F00D, 2);
        n_tests++;
        if (wcyc !== 3 || rcyc !== 0 || !pass_ok) begin
            n_fail++; $display("FAIL wmiss_forward: w=%0d r=%0d pass=%0d want 3 0 1", wcyc, rcyc, pass_ok);
        end
        model_step(1, 0, 32'h0000_0808, 0);
        access(1, 0, 32'h0000_0808, 0, 2);
        n_tests++;
        if (rcyc !== 3 || rd !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL wmiss_noalloc: r=%0d rdata=%h want 3 cafef00d", rcyc, rd);
        end
    endtask

    task automatic test_lru();
        logic [31:0] seq [6];
        int          want_r [6];
        seq = '{32'h404, 32'h504, 32'h404, 32'h604, 32'h404, 32'h504};
        want_r = '{0, 2, 0, 2, 0, 2};
        for (int k = 0; k < 6; k++) begin
            model_step(1, 0, seq[k], 0);
            access(1, 0, seq[k], 0, 1);
            n_tests++;
            if (rcyc !== want_r[k] || rd !== erd) begin
                n_fail++;
                $display("FAIL lru_step%0d: addr=%h r=%0d rdata=%h want %0d %h", k, seq[k], rcyc, rd, want_r[k], erd);
            end
        end
    endtask

    task automatic test_reset_mid_miss();
        @(negedge clk);
        MEM_R_EN = 1; MEM_W_EN = 0; address = 32'h0000_0C0C; wdata = 0; sram_ready = 0;
        @(negedge clk);
        #1;
        n_tests++;
        if (sram_r_en !== 1'b1) begin n_fail++; $display("FAIL rmid_started: r_en=%b want 1", sram_r_en); end
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        rst = 1; MEM_R_EN = 0;
        #1;
        n_tests++;
        if (sram_r_en !== 1'b0 || ready !== 1'b1 || rdata !== 32'h0) begin
            n_fail++; $display("FAIL rmid_idle: r_en=%b ready=%b rdata=%h want 0 1 0", sram_r_en, ready, rdata);
        end
        model_reset();
        model_step(1, 0, 32'h0000_0404, 0);
        access(1, 0, 32'h0000_0404, 0, 1);
        n_tests++;
        if (rcyc !== 2 || rd !== erd) begin
            n_fail++; $display("FAIL rmid_invalid: r=%0d rdata=%h want 2 %h", rcyc, rd, erd);
        end
    endtask

    task automatic test_simultaneous();
        model_step(1, 1, 32'h0000_0404, 32'h5555_AAAA);
        access(1, 1, 32'h0000_0404, 32'h5555_AAAA, 2);
        n_tests++;
        if (wcyc !== 3 || rcyc !== 0 || both !== 0) begin
            n_fail++; $display("FAIL simul_write: w=%0d r=%0d both=%0d want 3 0 0", wcyc, rcyc, both);
        end
        model_step(1, 0, 32'h0000_0404, 0);
        access(1, 0, 32'h0000_0404, 0, 2);
        n_tests++;
        if (low !== 0 || rd !== 32'h5555_AAAA) begin
            n_fail++; $display("FAIL simul_readback: low=%0d rdata=%h want 0 5555aaaa", low, rd);
        end
    endtask

    task automatic test_random();
        logic [31:0] a, wd;
        logic        re, we;
        int          lat, exp_low;
        for (int k = 0; k < 80; k++) begin
            a   = {13'h0, 9'h0, 2'(($urandom % 4)), 6'(1 + ($urandom % 3)), 2'(($urandom % 4))};
            wd  = $urandom;
            we  = ($urandom % 3) == 0;
            re  = !we || (($urandom % 2) == 0);
            lat = int'($urandom_range(0, 4));
            model_step(re, we, a, wd);
            access(re, we, a, wd, lat);
            exp_low = sop ? lat + 1 : 0;
            n_tests++;
            if (tmo || low !== exp_low || rd !== erd || both || en_after || !pass_ok
                || rcyc !== ((sop && !we) ? lat + 1 : 0) || wcyc !== (we ? lat + 1 : 0)) begin
                n_fail++;
                $display("FAIL rand%0d: a=%h re=%b we=%b low=%0d/%0d rdata=%h/%h r=%0d w=%0d tmo=%0d",
                         k, a, re, we, low, exp_low, rd, erd, rcyc, wcyc, tmo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_read();
        test_write_hit();
        test_write_miss();
        test_lru();
        test_reset_mid_miss();
        test_simultaneous();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_cache_controller.md
# mem_cache_controller

- Two-way set-associative, write-through, no-write-allocate data cache.
- Sits between the MEM stage and the SRAM controller: takes MEM-stage word requests, serves read hits with zero added latency, and forwards misses and all writes to the SRAM controller over its W_EN/R_EN/ready handshake.
- While a request is outstanding it deasserts `ready`, and the pipeline freezes.

## Interface
Parameters:
- SETS, 64, number of sets (one 32-bit word per way)
- INDEX_W, 6, log2(SETS); index = address[INDEX_W+1:2]
- TAG_W, 11, tag = address[18:INDEX_W+2]

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  synchronous, active-low reset; sampled on rising clk; all state cleared while low
- address  input  32  MEM-stage byte address; bits [1:0] ignored
- wdata  input  32  MEM-stage store data
- MEM_R_EN  input  1  load request
- MEM_W_EN  input  1  store request
- rdata  output  32  load data
- ready  output  1  high = request complete or no request; low = freeze pipeline
- sram_address  output  32  address to SRAM controller (equals `address`)
- sram_wdata  output  32  store data to SRAM controller (equals `wdata`)
- sram_w_en  output  1  write enable to SRAM controller
- sram_r_en  output  1  read enable to SRAM controller
- sram_rdata  input  32  read data from SRAM controller
- sram_ready  input  1  one-cycle completion pulse from SRAM controller

## Operation
Storage, per set:
- valid0, valid1
- tag0, tag1 (TAG_W bits each)
- data0, data1 (32 bits each)
- lru bit: lru=0 means the victim is way0; lru=1 means the victim is way1

Hit detection:
- hitN = validN and tagN == address tag.
- hit = hit0 or hit1.

States:
- IDLE
  - No request: ready=1; both sram enables are 0.
  - Read hit: rdata is the hit way's data, ready=1 in the same cycle. At the edge, lru points away from the hit way (hit0 sets lru=1; hit1 sets lru=0).
  - Read miss: ready=0; next state MISS_READ.
  - Write (MEM_W_EN=1, with or without MEM_R_EN; write has priority): ready=0; next state WRITE_THRU.
- MISS_READ
  - sram_r_en=1 and ready=0 until sram_ready=1.
  - Completion cycle (sram_ready=1):
    - rdata=sram_rdata and ready=1.
    - Fill way: way0 if !valid0; else way1 if !valid1; else the lru victim.
    - At the edge: write tag, data and valid=1 into the fill way; set lru away from the fill way; next state IDLE.
- WRITE_THRU
  - sram_w_en=1 and ready=0 until sram_ready=1.
  - Completion cycle: ready=1.
    - Write hit: the hit way's data is replaced with wdata and lru is updated as for a read hit.
    - Write miss: cache contents are unchanged (no allocation).
    - Next state IDLE.

Outputs and mode:
- sram_address and sram_wdata are continuous pass-throughs.
- rdata is 0 when it is neither a hit nor a miss-completion cycle.
- The MEM stage holds address, wdata and the enables stable while ready=0. This block relies on that and does not latch its inputs.

Reset (rst=0 at an edge):
- State becomes IDLE.
- All valid and lru bits are cleared.
- Tag and data arrays are unspecified.
- Outputs after reset: sram_r_en=0, sram_w_en=0; ready=1 if no request, otherwise per IDLE rules.
- A reset mid-miss or mid-write abandons the transaction with no fill. The SRAM controller shares the reset and abandons its own transaction.

## Timing
- Read hit: 0 extra cycles (combinational ready and rdata).
- Miss or write: 1 cycle in IDLE, then N cycles in MISS_READ or WRITE_THRU, where N counts through the sram_ready cycle. ready is high only in that final cycle.
- sram_r_en and sram_w_en are state-decoded (registered state) and drop in the cycle after sram_ready. They never re-assert without returning to IDLE first.
- sram_ready while in IDLE is ignored.
- sram_r_en and sram_w_en are never both 1.

## Test plan
- Cold read:
  - Stimulus: release reset, then read 0x0000_0404 (index 1); SRAM model returns 0xDEAD_BEEF after 5 cycles.
  - Required: ready low for 6 cycles; rdata=0xDEAD_BEEF on the sram_ready cycle.
  - Then re-read 0x0000_0404: ready=1 in the same cycle, sram_r_en stays 0.
- Write hit:
  - Stimulus: after the cold read above, write 0x1234_5678 to 0x0000_0404.
  - Required: sram_w_en held until sram_ready.
  - Then read 0x0000_0404: a hit returning 0x1234_5678.
- Write miss:
  - Stimulus: write to 0x0000_0808.
  - Required: forwarded to SRAM.
  - Then read 0x0000_0808: misses (sram_r_en=1), confirming no allocate.
- LRU eviction:
  - Stimulus: read 0x404, read 0x504, read 0x404 again (hit), then read 0x604.
  - Required: 0x604 replaces 0x504 (way1).
  - Then 0x404 hits, and 0x504 misses.
- Reset mid-miss:
  - Stimulus: start a read miss on 0x0000_0C0C; assert rst=0 for one edge two cycles in.
  - Required: sram_r_en=0 the next cycle, state IDLE, all sets invalid (a re-read of 0x404 misses).
- Simultaneous enables:
  - Stimulus: MEM_R_EN=MEM_W_EN=1 to 0x0000_0404.
  - Required: only sram_w_en asserts; handled as a write.
